// File: rtl/rvsteel_debouncer_pkg.sv
// Shared elaboration helpers for the debouncer: cycle-count derivation and
// counter sizing used by both the top and the per-channel block.
package rvsteel_debouncer_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    int unsigned rest;
    width = 0;
    if (value > 1) begin
      rest = value - 1;
      while (rest > 0) begin
        width = width + 1;
        rest  = rest >> 1;
      end
    end
    return width;
  endfunction

  function automatic int unsigned db_cycles(input int unsigned clock_frequency,
                                            input int unsigned debounce_us);
    int unsigned cycles;
    cycles = clock_frequency / 1000000 * debounce_us;
    return (cycles < 1) ? 1 : cycles;
  endfunction

  function automatic int unsigned lp_cycles(input int unsigned clock_frequency,
                                            input int unsigned long_press_ms);
    return clock_frequency / 1000 * long_press_ms;
  endfunction

  // A counter must hold 0..max_count; a zero-width vector is never legal.
  function automatic int unsigned counter_width(input int unsigned max_count);
    int unsigned width;
    width = clog2(max_count + 1);
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/rvsteel_debouncer_channel.sv
// One debounced input: optional inversion, synchronizer, stability counter,
// edge pulses and a saturating hold counter for the long-press event.
module rvsteel_debouncer_channel
  import rvsteel_debouncer_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = 1,
  parameter int unsigned LP_CYCLES   = 0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        INVERT      = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_in,
  output logic level_out,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse
);

  localparam int unsigned DB_W = counter_width(DB_CYCLES);
  localparam int unsigned LP_W = counter_width(LP_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LP_CYCLES);
  localparam logic [LP_W-1:0] LP_LAST = LP_W'((LP_CYCLES == 0) ? 0 : LP_CYCLES - 1);
  localparam logic            LP_ENABLE = (LP_CYCLES != 0);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic [LP_W-1:0]        hold_q, hold_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   long_q, long_d;
  logic                   synced;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], raw_in ^ INVERT};
    synced   = sync_q[SYNC_STAGES-1];
    level_d  = level_q;
    db_cnt_d = '0;
    if (synced != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = synced;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    // Counting starts the cycle after the level rises, so the hold count
    // equals the number of cycles the new level has been visible.
    hold_d = '0;
    if (level_d) begin
      hold_d = hold_q;
      if (level_q && (hold_q != LP_MAX)) begin
        hold_d = hold_q + 1'b1;
      end
    end

    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
    long_d    = LP_ENABLE & level_q & level_d & (hold_q == LP_LAST);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      db_cnt_q  <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      db_cnt_q  <= db_cnt_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign level_out        = level_q;
  assign press_pulse      = press_q;
  assign release_pulse    = release_q;
  assign long_press_pulse = long_q;

endmodule

// File: rtl/rvsteel_debouncer.sv
// Multi-channel button debouncer: derives cycle counts from the clock and
// timing parameters, then replicates one independent channel per input.
module rvsteel_debouncer
  import rvsteel_debouncer_pkg::*;
#(
  parameter int unsigned          CHANNELS        = 2,
  parameter int unsigned          CLOCK_FREQUENCY = 12000000,
  parameter int unsigned          DEBOUNCE_US     = 10000,
  parameter int unsigned          SYNC_STAGES     = 2,
  parameter logic [CHANNELS-1:0]  ACTIVE_LOW      = {CHANNELS{1'b0}},
  parameter int unsigned          LONG_PRESS_MS   = 1000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] long_press_pulse
);

  localparam int unsigned DB_CYCLES = db_cycles(CLOCK_FREQUENCY, DEBOUNCE_US);
  localparam int unsigned LP_CYCLES = lp_cycles(CLOCK_FREQUENCY, LONG_PRESS_MS);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    rvsteel_debouncer_channel #(
      .DB_CYCLES  (DB_CYCLES),
      .LP_CYCLES  (LP_CYCLES),
      .SYNC_STAGES(SYNC_STAGES),
      .INVERT     (ACTIVE_LOW[i])
    ) u_channel (
      .clock           (clock),
      .reset_n         (reset_n),
      .raw_in          (raw_in[i]),
      .level_out       (level_out[i]),
      .press_pulse     (press_pulse[i]),
      .release_pulse   (release_pulse[i]),
      .long_press_pulse(long_press_pulse[i])
    );
  end

endmodule

// File: doc/rvsteel_debouncer.md
RVSTEEL_DEBOUNCER -- requirements
Module: rvsteel_debouncer

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent input channels (1..32).
REQ-002 SHALL have parameter CLOCK_FREQUENCY, default 12000000: clock frequency in Hz.
REQ-003 SHALL have parameter DEBOUNCE_US, default 10000: required input stability time in microseconds.
REQ-004 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth (2..4).
REQ-005 SHALL have parameter ACTIVE_LOW, default {CHANNELS{1'b0}}: per-channel bit; 1 means the raw input is inverted before processing.
REQ-006 SHALL have parameter LONG_PRESS_MS, default 1000: hold time for a long-press event; 0 disables long-press.
REQ-007 SHALL have port clock, input, 1: single clock; all logic on its rising edge.
REQ-008 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have port raw_in, input, CHANNELS: asynchronous button/switch inputs.
REQ-010 SHALL have port level_out, output, CHANNELS: debounced, active-high level.
REQ-011 SHALL have port press_pulse, output, CHANNELS: one-cycle pulse on each debounced 0->1 transition.
REQ-012 SHALL have port release_pulse, output, CHANNELS: one-cycle pulse on each debounced 1->0 transition.
REQ-013 SHALL have port long_press_pulse, output, CHANNELS: one-cycle pulse when a press has been held LONG_PRESS_MS.

Function
REQ-014 SHALL compute DB_CYCLES = max(1, CLOCK_FREQUENCY/1000000*DEBOUNCE_US) and LP_CYCLES = CLOCK_FREQUENCY/1000*LONG_PRESS_MS at elaboration.
REQ-015 SHALL size the debounce counter as clog2(DB_CYCLES+1) bits and the hold counter as clog2(LP_CYCLES+1) bits; neither counter shall wrap.
REQ-016 SHALL pass each channel through ACTIVE_LOW inversion followed by a SYNC_STAGES flop chain; the chain output is "synced".
REQ-017 SHALL, while synced equals level_out, hold that channel's debounce counter at 0, so any glitch shorter than DB_CYCLES is rejected.
REQ-018 SHALL, while synced differs from level_out, increment the counter each cycle; on the cycle the counter equals DB_CYCLES-1, the next edge updates level_out to synced and clears the counter.
REQ-019 SHALL change level_out exactly SYNC_STAGES+DB_CYCLES cycles after a stable change at raw_in is first sampled.
REQ-020 SHALL assert press_pulse/release_pulse for exactly the one cycle in which level_out shows its new value, registered, never both at once on one channel.
REQ-021 SHALL run the hold counter while level_out=1, saturating at LP_CYCLES, and clear it on the cycle level_out returns to 0.
REQ-022 SHALL pulse long_press_pulse once, for one cycle, when the hold counter reaches LP_CYCLES; no repeat until after a release; never when LONG_PRESS_MS=0.
REQ-023 SHALL process channels fully independently; simultaneous events on multiple channels all produce their own pulses in the same cycle.

Reset
REQ-024 SHALL, on reset_n=0, asynchronously clear synchronizer flops, counters, level_out, press_pulse, release_pulse and long_press_pulse to 0 (post-inversion inactive level).
REQ-025 SHALL, on reset_n deassertion while an input is already active, report it as a normal press after SYNC_STAGES+DB_CYCLES cycles, with press_pulse.
REQ-026 SHALL, on reset mid-debounce or mid-hold, discard all partial counts; no pulse is emitted for the interrupted event.

Structure
REQ-027 SHALL place the DB_CYCLES/LP_CYCLES computation functions and the clog2 helper in shared package rvsteel_debouncer_pkg.
REQ-028 SHALL implement one channel in sub-module rvsteel_debouncer_channel, instantiated CHANNELS times via generate; the top contains no per-channel logic.

Verification (CLOCK_FREQUENCY=1000000, DEBOUNCE_US=4 -> DB_CYCLES=4, SYNC_STAGES=2, LONG_PRESS_MS=1 -> LP_CYCLES=1000, CHANNELS=2)
REQ-029 SHALL check a clean press: raw_in[0] 0->1 held -> level_out[0]=1 exactly 6 cycles later; press_pulse[0] high 1 cycle; channel 1 unaffected.
REQ-030 SHALL check glitch rejection: raw_in[0] high for 3 cycles, then low -> level_out[0] stays 0; no pulses.
REQ-031 SHALL check long press: hold raw_in[1] for 1100 cycles -> one long_press_pulse[1] at cycle 1000 after level_out[1] rises; release -> release_pulse[1] 6 cycles after raw falls.
REQ-032 SHALL check ACTIVE_LOW=2'b01: raw_in[0] 1->0 -> press_pulse[0] after 6 cycles; raw_in[1] 1->0 -> release behaviour only if previously pressed.
REQ-033 SHALL check reset mid-operation: assert reset_n=0 on cycle 3 of debounce -> all outputs 0 immediately; input still high after release of reset -> press_pulse 6 cycles later.
REQ-034 SHALL check simultaneous events: both channels rise on the same cycle -> press_pulse=2'b11 in one cycle.
